// File: rtl/synth_cfg_ctrl.sv
// synth_cfg_ctrl: MMIO shadow registers committed to synth config outputs
// through a four-phase req/ack handshake with timeout.
module synth_cfg_ctrl #(
  parameter int N_VOICES    = 1,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mmio_we,
  input  logic                    mmio_re,
  input  logic [7:0]              mmio_addr,
  input  logic [31:0]             mmio_wdata,
  output logic [31:0]             mmio_rdata,
  output logic [24*N_VOICES-1:0]  cfg_carrier_fcws,
  output logic [23:0]             cfg_mod_fcw,
  output logic [4:0]              cfg_mod_shift,
  output logic [N_VOICES-1:0]     cfg_note_en,
  output logic [4:0]              cfg_synth_shift,
  output logic                    cpu_req,
  input  logic                    cpu_ack,
  output logic                    done
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tmo;
  logic [24*N_VOICES-1:0] sh_car;
  logic [23:0] sh_mod_fcw;
  logic [4:0] sh_mod_shift, sh_synth_shift;
  logic [N_VOICES-1:0] sh_note_en;
  logic pending, err, busy, start, abort, finish;
  logic wr_commit, wr_status;
  logic [5:0] word;
  logic [31:0] rd_val;
  logic unused_bits;
  assign word = mmio_addr[7:2];
  assign wr_commit = mmio_we && word == 6'd12;
  assign wr_status = mmio_we && word == 6'd13;
  assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:24]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tmo <= '0;
    end else begin
      state <= state_nx;
      tmo <= (state_nx != state || !busy) ? '0 : tmo + TW'(1);
    end
  always_comb
    state_nx = start ? REQ :
               (state == REQ && cpu_ack) ? REL :
               (finish || abort) ? IDLE : state;
  // abort only when the handshake phase is still waiting on the CDC
  always_comb begin
    busy = state != IDLE;
    cpu_req = state == REQ;
    start = state == IDLE && (wr_commit || pending);
    finish = state == REL && !cpu_ack;
    abort = tmo == TW'(ACK_TIMEOUT - 1) &&
            (state == REQ ? !cpu_ack : state == REL && cpu_ack);
  end
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_VOICES; i++)
      if (word == 6'(i)) rd_val = {8'd0, sh_car[24*i +: 24]};
    case (word)
      6'd8:  rd_val = {8'd0, sh_mod_fcw};
      6'd9:  rd_val = {27'd0, sh_mod_shift};
      6'd10: rd_val = 32'(sh_note_en);
      6'd11: rd_val = {27'd0, sh_synth_shift};
      6'd13: rd_val = {29'd0, err, pending, busy};
      default: ;
    endcase
  end
  // cfg_* sample the shadows before any same-edge shadow write lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_car <= '0;
      sh_mod_fcw <= '0;
      sh_mod_shift <= '0;
      sh_note_en <= '0;
      sh_synth_shift <= '0;
      cfg_carrier_fcws <= '0;
      cfg_mod_fcw <= '0;
      cfg_mod_shift <= '0;
      cfg_note_en <= '0;
      cfg_synth_shift <= '0;
      pending <= 1'b0;
      err <= 1'b0;
      done <= 1'b0;
      mmio_rdata <= '0;
    end else begin
      for (int i = 0; i < N_VOICES; i++)
        if (mmio_we && word == 6'(i)) sh_car[24*i +: 24] <= mmio_wdata[23:0];
      if (mmio_we && word == 6'd8) sh_mod_fcw <= mmio_wdata[23:0];
      if (mmio_we && word == 6'd9) sh_mod_shift <= mmio_wdata[4:0];
      if (mmio_we && word == 6'd10) sh_note_en <= mmio_wdata[N_VOICES-1:0];
      if (mmio_we && word == 6'd11) sh_synth_shift <= mmio_wdata[4:0];
      if (start) begin
        cfg_carrier_fcws <= sh_car;
        cfg_mod_fcw <= sh_mod_fcw;
        cfg_mod_shift <= sh_mod_shift;
        cfg_note_en <= sh_note_en;
        cfg_synth_shift <= sh_synth_shift;
      end
      pending <= start ? 1'b0 : (wr_commit && busy) ? 1'b1 : pending;
      err <= abort ? 1'b1 : (wr_status && mmio_wdata[2]) ? 1'b0 : err;
      done <= finish;
      if (mmio_re) mmio_rdata <= rd_val;
    end
endmodule

// File: doc/synth_cfg_ctrl.md
SYNTH_CFG_CTRL -- requirements
Module: synth_cfg_ctrl

Interface
REQ-001 Parameter N_VOICES, default 1: number of carrier voices, legal range 1..8.
REQ-002 Parameter ACK_TIMEOUT, default 1024: maximum cycles spent in either handshake phase before abort.
REQ-003 clk  in  1  CPU clock. The block has one clock.
REQ-004 rst_n  in  1  Reset, asynchronous and active-low.
REQ-005 mmio_we  in  1  Register write strobe, single cycle.
REQ-006 mmio_re  in  1  Register read strobe, single cycle.
REQ-007 mmio_addr  in  8  Byte address; bits [1:0] are ignored.
REQ-008 mmio_wdata  in  32  Write data.
REQ-009 mmio_rdata  out  32  Read data, registered.
REQ-010 cfg_carrier_fcws  out  24*N_VOICES  Committed carrier FCWs; voice i occupies bits [24i+23:24i].
REQ-011 cfg_mod_fcw  out  24  Committed modulator FCW.
REQ-012 cfg_mod_shift  out  5  Committed modulator shift.
REQ-013 cfg_note_en  out  N_VOICES  Committed note enables.
REQ-014 cfg_synth_shift  out  5  Committed synth output shift.
REQ-015 cpu_req  out  1  Four-phase request to the CPU-to-synth CDC.
REQ-016 cpu_ack  in  1  Acknowledge from the CDC, already synchronous to clk.
REQ-017 done  out  1  One-cycle pulse when a transfer completes successfully.

Function
REQ-018 Address map:
- 0x00+4i: shadow carrier FCW i, bits [23:0], for i < N_VOICES.
- 0x20: shadow mod_fcw [23:0].
- 0x24: shadow mod_shift [4:0].
- 0x28: shadow note_en [N_VOICES-1:0].
- 0x2C: shadow synth_shift [4:0].
- 0x30: COMMIT, write-only, data ignored.
- 0x34: STATUS, bit0 busy, bit1 pending, bit2 err.
REQ-019 Shadow registers shall update on the cycle after mmio_we with matching address; unused upper data bits are discarded.
REQ-020 A read shall return the shadow value zero-extended on mmio_rdata one cycle after mmio_re; unmapped addresses and COMMIT shall read 0.
REQ-021 A write to STATUS with bit2=1 shall clear err; all other STATUS bits are read-only.
REQ-022 The state machine shall have three states: IDLE, REQ and REL.
REQ-023 In IDLE, when a commit is requested (COMMIT write or pending=1):
- all shadow registers are copied into the cfg_* outputs on the same edge;
- cpu_req rises next cycle;
- the state becomes REQ;
- pending clears.
REQ-024 In REQ, cpu_req=1; when cpu_ack=1 the state shall move to REL and cpu_req shall fall.
REQ-025 In REL, cpu_req=0; when cpu_ack=0 the state shall return to IDLE with done=1 for one cycle.
REQ-026 cfg_* outputs shall change only on the IDLE-to-REQ edge and shall stay stable throughout REQ and REL.
REQ-027 A COMMIT write while busy (REQ or REL) shall set pending; further commits while pending is set merge into it. On return to IDLE with pending=1, a new transfer starts using the shadow values current at that edge.
REQ-028 Shadow writes while busy are accepted and shall not affect the cfg_* outputs until the next transfer.
REQ-029 A COMMIT write on the same cycle as a shadow write shall latch the pre-write shadow value into cfg_*; the new value takes effect only at the next commit.
REQ-030 The timeout counter shall reset on every state entry and increment each cycle in REQ or REL.
REQ-031 On reaching ACK_TIMEOUT-1:
- err is set;
- cpu_req falls;
- the state returns to IDLE;
- no done pulse is generated;
- pending is preserved.
REQ-032 busy=1 exactly when the state is REQ or REL.

Reset
REQ-033 On rst_n low, asynchronously:
- state=IDLE;
- all shadow and cfg_* registers=0;
- cpu_req=0, done=0, pending=0, err=0, mmio_rdata=0;
- timeout counter=0.
REQ-034 Reset asserted mid-transfer shall drop cpu_req immediately and discard any pending commit.

Verification
REQ-035 Write 0x20=0x123456, then COMMIT; ack rises 3 cycles after req and falls 3 cycles after release -> cfg_mod_fcw=0x123456 on the cycle after COMMIT, a single req pulse, done pulses once, STATUS reads 0.
REQ-036 COMMIT, then while in REQ write 0x24=7 and COMMIT twice -> pending=1, then exactly two transfers in total, with the second carrying cfg_mod_shift=7.
REQ-037 ACK_TIMEOUT=16 with ack held at 0 after COMMIT -> cpu_req falls after 16 cycles, STATUS=0x4, no done pulse; writing STATUS=0x4 then reads 0.
REQ-038 N_VOICES=4: write voices 0..3 with 0x10,0x20,0x30,0x40 and 0x28=0xF, then COMMIT -> cfg_carrier_fcws={0x40,0x30,0x20,0x10}, cfg_note_en=0xF; reads of 0x50 return 0.
REQ-039 Assert rst_n low while in REL -> cpu_req=0, all cfg_*=0 and STATUS=0 immediately; no done pulse after release of reset.
